// File: rtl/recv_byte.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : recv_byte
//  Purpose  : 8N1 UART receiver. Synchronizes the asynchronous serial line,
//             validates the start bit at mid-period, majority-samples each
//             data bit and the stop bit, then strobes either rx_done (byte
//             accepted into rx_data) or frame_err (bad stop bit, byte dropped).
//             Baud encoding matches the send_byte transmitter.
//  Ports    : sys_clk   - system clock, rising edge
//             rst_n     - asynchronous active-low reset
//             time_set  - baud select: 0=4800, 1=9600, other=115200
//             uart_rx   - serial input, idle high, asynchronous
//             rx_data   - last good received byte (LSB first on the line)
//             rx_done   - 1-cycle pulse, rx_data just updated
//             frame_err - 1-cycle pulse, stop bit sampled low
//             rx_busy   - high from start-edge detect until the frame ends
//  Revision : 1.0 - initial release
// ============================================================================
module recv_byte (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [2:0] time_set,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  // Clocks per bit at 50 MHz, identical to the transmitter.
  localparam logic [13:0] DIV_4800   = 14'd10416;
  localparam logic [13:0] DIV_9600   = 14'd5208;
  localparam logic [13:0] DIV_115200 = 14'd434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state;

  logic        rx_meta;   // first synchronizer stage
  logic        rx_s;      // synchronized line
  logic        rx_s_d;    // delayed copy for falling-edge detect
  logic [2:0]  smp;       // last three synchronized samples
  logic        maj;       // 2-of-3 vote over smp

  logic [13:0] div_sel;   // divisor decoded from the live time_set
  logic [13:0] tc;        // divisor latched for the current frame
  logic [13:0] half;
  logic [13:0] tc_last;
  logic [13:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  shreg;

  always_comb begin
    case (time_set)
      3'd0:    div_sel = DIV_4800;
      3'd1:    div_sel = DIV_9600;
      default: div_sel = DIV_115200;
    endcase
  end

  assign half    = tc >> 1;
  assign tc_last = tc - 14'd1;
  assign maj     = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  // Synchronizer, edge-detect delay and voting window. All reset to the idle
  // (high) level so that releasing reset never looks like a start edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
      smp     <= 3'b111;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
      smp     <= {smp[1:0], rx_s};
    end
  end

  // Frame state machine. Strobes default low every cycle so each one is
  // exactly one clock wide.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tc        <= 14'd0;
      cnt       <= 14'd0;
      bitn      <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          // Only a high-to-low transition starts a frame, so a line stuck
          // low after a break cannot retrigger until it goes high again.
          if (rx_s_d && !rx_s) begin
            state   <= START;
            cnt     <= 14'd0;
            tc      <= div_sel;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == half) begin
            cnt <= 14'd0;
            if (!maj) begin
              state <= DATA;
              bitn  <= 3'd0;
            end else begin
              // Line already back high at mid start bit: glitch, not a frame.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 14'd1;
          end
        end

        DATA: begin
          // Counting starts from mid start bit, so tc_last lands mid-bit.
          if (cnt == tc_last) begin
            cnt         <= 14'd0;
            shreg[bitn] <= maj;
            if (bitn == 3'd7) begin
              state <= STOP;
            end else begin
              bitn <= bitn + 3'd1;
            end
          end else begin
            cnt <= cnt + 14'd1;
          end
        end

        STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch the next
          // start edge of a back-to-back frame.
          if (cnt == tc_last) begin
            cnt <= 14'd0;
            if (maj) begin
              rx_data <= shreg;
              rx_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else begin
            cnt <= cnt + 14'd1;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_recv_byte.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_recv_byte
//  Purpose  : Self-checking bench for recv_byte. Drives 8N1 frames on the
//             serial line and checks received bytes, strobes, busy window
//             and latency against expectations derived from frame rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_recv_byte;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] time_set;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  recv_byte dut (
    .sys_clk   (clk),
    .rst_n     (rst_n),
    .time_set  (time_set),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- monitor
  logic [7:0] done_q[$];
  int         done_cyc_q[$];
  int         err_n = 0;
  int         overlap_n = 0;
  int         wide_n = 0;
  logic       prev_done = 1'b0;
  logic       prev_err = 1'b0;
  int         busy_run = 0;
  int         last_busy_len = 0;

  always @(negedge clk) begin
    if (rx_done) begin
      done_q.push_back(rx_data);
      done_cyc_q.push_back(cyc);
    end
    if (frame_err) err_n++;
    if (rx_done && frame_err) overlap_n++;
    if ((rx_done && prev_done) || (frame_err && prev_err)) wide_n++;
    prev_done = rx_done;
    prev_err  = frame_err;
    if (rx_busy) busy_run++;
    else begin
      if (busy_run != 0) last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  // ---------------------------------------------------------------- checks
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input int act, input int exp, input int tol);
    compared++;
    if (act < exp - tol || act > exp + tol) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic int bit_per(input logic [2:0] ts);
    case (ts)
      3'd0:    return 10416;
      3'd1:    return 5208;
      default: return 434;
    endcase
  endfunction

  logic [7:0] model_data = 8'h00;
  int         start_cyc = 0;

  // Drive one frame, each bit exactly per cycles. Optional single-cycle low
  // glitch inside data bit gbit (only when that bit is 1).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per,
                            input int gbit, input int goff);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        uart_rx = bits[i];
        if (gbit >= 0 && i == gbit + 1 && c == goff && bits[i]) uart_rx = 1'b0;
        if (i == 0 && c == 0) start_cyc = cyc;
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (n - 1) @(negedge clk);
    #2;
  endtask

  task automatic run_frame(input string nm, input logic [7:0] b, input logic stop,
                           input int per, input int gbit, input int goff,
                           input int exp_done, input int exp_err, input logic [7:0] exp_rx);
    int d0;
    int e0;
    d0 = done_q.size();
    e0 = err_n;
    last_busy_len = 0;
    send_frame(b, stop, per, gbit, goff);
    idle(40);
    chk({nm, " done_count"}, done_q.size() - d0, exp_done);
    chk({nm, " err_count"}, err_n - e0, exp_err);
    chk({nm, " rx_data"}, rx_data, exp_rx);
    chk({nm, " busy_after"}, rx_busy, 0);
    chk_near({nm, " busy_len"}, last_busy_len, per / 2 + 9 * per, 3);
    if (exp_done == 1 && done_q.size() - d0 == 1)
      chk_near({nm, " latency"}, done_cyc_q[$] - start_cyc, per / 2 + 9 * per + 3, 3);
  endtask

  task automatic false_start(input string nm, input logic [2:0] ts, input int exp_half,
                             input int wait_n);
    int d0;
    int e0;
    time_set = ts;
    d0 = done_q.size();
    e0 = err_n;
    last_busy_len = 0;
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (99) @(negedge clk);
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (wait_n) @(negedge clk);
    #2;
    chk_near({nm, " busy_len"}, last_busy_len, exp_half, 3);
    chk({nm, " done_count"}, done_q.size() - d0, 0);
    chk({nm, " err_count"}, err_n - e0, 0);
    chk({nm, " busy_after"}, rx_busy, 0);
    chk({nm, " rx_data"}, rx_data, model_data);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [2:0] ts;
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int d0;
    int e0;
    logic [2:0] ts;
    logic [7:0] b;
    logic       stop;
    int         gbit;
    int         goff;
    int         ed;
    int         ee;

    vecs[0] = '{3'd2, 8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{3'd2, 8'h3C, 1'b0, 0, 1, 8'hA5};  // bad stop keeps old byte
    vecs[2] = '{3'd2, 8'h81, 1'b1, 1, 0, 8'h81};
    vecs[3] = '{3'd3, 8'h5A, 1'b1, 1, 0, 8'h5A};  // unlisted code -> 115200

    rst_n    = 1'b1;
    uart_rx  = 1'b1;
    time_set = 3'd2;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset rx_done", rx_done, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset rx_busy", rx_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(20);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      time_set = vecs[i].ts;
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop, bit_per(vecs[i].ts),
                -1, 0, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_rx);
      if (vecs[i].exp_done == 1) model_data = vecs[i].data;
    end

    // Short low pulses: rejected at mid start bit, busy lasts about half a bit
    false_start("glitch115200", 3'd2, 217, 300);
    false_start("glitch4800", 3'd0, 5208, 5400);

    // Break: line held low -> exactly one frame error, no retrigger
    time_set = 3'd2;
    d0 = done_q.size();
    e0 = err_n;
    @(negedge clk) uart_rx = 1'b0;
    repeat (12 * 434) @(negedge clk);
    #2;
    chk("break err_count", err_n - e0, 1);
    chk("break busy", rx_busy, 0);
    idle(600);
    chk("break err_total", err_n - e0, 1);
    chk("break done_count", done_q.size() - d0, 0);
    chk("break rx_data", rx_data, model_data);

    // Back-to-back frames with a single stop bit and no gap
    d0 = done_q.size();
    e0 = err_n;
    send_frame(8'h00, 1'b1, 434, -1, 0);
    send_frame(8'hFF, 1'b1, 434, -1, 0);
    idle(40);
    chk("b2b done_count", done_q.size() - d0, 2);
    chk("b2b err_count", err_n - e0, 0);
    if (done_q.size() - d0 == 2) begin
      chk("b2b first", done_q[d0], 8'h00);
      chk("b2b second", done_q[d0 + 1], 8'hFF);
      chk_near("b2b spacing", done_cyc_q[d0 + 1] - done_cyc_q[d0], 4340, 2);
    end
    model_data = 8'hFF;

    // Reset in the middle of bit 4
    fork
      send_frame(8'h5A, 1'b1, 434, -1, 0);
      begin
        repeat (5 * 434 + 100) @(negedge clk);
        #2;
        chk("midrst busy_before", rx_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst rx_data", rx_data, 8'h00);
        chk("midrst rx_done", rx_done, 0);
        chk("midrst frame_err", frame_err, 0);
        chk("midrst rx_busy", rx_busy, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    idle(3000);  // let the tail of the interrupted frame play out
    run_frame("after_reset", 8'h5A, 1'b1, 434, -1, 0, 1, 0, 8'h5A);
    model_data = 8'h5A;

    // Baud change mid-frame only affects the next frame
    time_set = 3'd2;
    d0 = done_q.size();
    e0 = err_n;
    fork
      send_frame(8'h96, 1'b1, 434, -1, 0);
      begin
        repeat (4 * 434 + 200) @(negedge clk);
        time_set = 3'd1;
      end
    join
    idle(40);
    chk("switch done_count", done_q.size() - d0, 1);
    chk("switch err_count", err_n - e0, 0);
    chk("switch rx_data", rx_data, 8'h96);
    model_data = 8'h96;
    false_start("next_at_9600", 3'd1, 2604, 2800);

    // Randomized frames with optional glitches, checked against frame rules
    for (int k = 0; k < 4; k++) begin
      ts   = 3'($urandom_range(2, 7));
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gbit = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
      goff = int'($urandom_range(0, 433));
      if (stop) begin
        ed = 1; ee = 0; model_data = b;
      end else begin
        ed = 0; ee = 1;
      end
      time_set = ts;
      run_frame($sformatf("rand%0d", k), b, stop, bit_per(ts), gbit, goff, ed, ee, model_data);
    end

    chk("strobe overlap", overlap_n, 0);
    chk("strobe width", wide_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/recv_byte.md
Name: recv_byte

Overview:
UART receiver. It is the receive-side counterpart of the team's send_byte transmitter and shares its 8N1 frame and time_set baud encoding. It takes the asynchronous serial line uart_rx, synchronizes it, validates the start bit and majority-samples each bit at mid-period. It then presents the byte on rx_data with a 1-cycle rx_done strobe, or a 1-cycle frame_err strobe if the stop bit is bad. It sits between the board RX pin and the byte-level command logic.

Parameters:
None. Baud divisors are fixed constants, identical to send_byte: 4800 -> 10416, 9600 -> 5208, 115200 -> 434 (50 MHz sys_clk).

Ports:
sys_clk   in   1  system clock, all logic on rising edge
rst_n     in   1  reset; one clock; reset is asynchronous and active-low
time_set  in   3  baud select: 0=4800 (10416), 1=9600 (5208), 2=115200 (434), other=115200 (434)
uart_rx   in   1  serial line, asynchronous, idle high
rx_data   out  8  last good received byte, LSB first on the line
rx_done   out  1  1-cycle pulse: rx_data was just updated
frame_err out  1  1-cycle pulse: stop bit sampled 0, byte discarded
rx_busy   out  1  high from start-edge detect until the frame ends (good, error or false start)

Behaviour:
- Reset values: rx_data=8'h00, rx_done=0, frame_err=0, rx_busy=0, FSM=IDLE, all counters=0, synchronizer and sample shift register=all 1s.
- Synchronizer: 2 flops, uart_rx -> rx_s. A third flop rx_s_d is used for edge detect. A 3-bit shift register smp holds the last 3 rx_s values.
- maj = majority(smp).
- Baud latch: tc = divisor(time_set), captured on IDLE->START. tc is constant for the whole frame. A time_set change mid-frame takes effect on the next frame only.
- half = tc >> 1 (217 / 2604 / 5208).
- cnt: 14-bit bit-period counter. bitn: 3-bit data index.
- FSM:
  - IDLE: rx_s_d=1 and rx_s=0 (falling edge) -> START, cnt=0, rx_busy=1.
  - START: cnt increments each cycle. At cnt==half: if maj=0, go to DATA with cnt=0 and bitn=0. If maj=1 (false start/glitch), go to IDLE and drop rx_busy. No strobes either way.
  - DATA: cnt counts 0..tc-1 and wraps. At cnt==tc-1, shift maj into shreg[bitn] (LSB first). If bitn==7, go to STOP with cnt=0; else bitn++.
  - STOP: at cnt==tc-1, sample maj.
    - maj=1: rx_data<=shreg, rx_done<=1.
    - maj=0: frame_err<=1, rx_data unchanged.
    - Either way go to IDLE and drop rx_busy.
- Strobe timing: strobes are registered and high exactly 1 cycle, the cycle after the stop decision. rx_done and frame_err are never both high.
- Latency: the stop decision falls half + 9*tc cycles after the edge-detect cycle. At 115200 that is 217+3906 = 4123 cycles, so rx_done rises at 4124 (±1). Add 2-3 cycles from the pin because of the synchronizer.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge arriving immediately after the stop bit is caught. Stop bits shorter than half a bit are not supported.
- Line held low (break): frame_err pulses once. The FSM then waits in IDLE for a new falling edge, which requires the line to return high first. No repeated errors.
- Reset mid-frame: everything returns to reset values immediately. Any partial byte is lost, and rx_data is cleared to 0.
- Glitch immunity: a low pulse of at most 1 cycle at a sample point is outvoted by majority. A low pulse shorter than half a bit at the start is rejected by the START check.

Test Plan:
1. time_set=2, send 0xA5 8N1 at 434 clk/bit -> rx_done single pulse ~4126 cycles after the start edge on the pin, rx_data=8'hA5, frame_err=0, rx_busy high throughout the frame.
2. time_set=1, send 0x00 then 0xFF back-to-back (1 stop bit, no gap) -> two rx_done pulses 52080 cycles apart, rx_data=8'h00 then 8'hFF.
3. time_set=2, uart_rx low for 100 cycles then high -> rx_busy pulses ~217 cycles, no rx_done, no frame_err, FSM back in IDLE.
4. time_set=2, send 0x3C with stop bit=0, then a valid 0x81 -> first frame: frame_err pulse, rx_data keeps its prior value; second frame: rx_done, rx_data=8'h81.
5. time_set=0, start 0x5A, assert rst_n=0 for 5 cycles at bit 4 -> outputs at reset values immediately; next full 0x5A received correctly.
6. time_set=2 frame 0x96, switch time_set to 1 during bit 3 -> byte received at 434 clk/bit, rx_data=8'h96; the following frame is sent at 5208 clk/bit and received correctly.
